instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of `controlpath`. It owns the program counter and fetches one 32-bit instruction word at a time from instruction memory over a req/ack handshake. It presents that word on `instruction`, holds `wait_instr` high while no valid word is available, and raises `instr_segv` on an out-of-range, misaligned or erroring fetch. It advances on `pc_inc` and redirects on `pc_load`, including a redirect that arrives while a fetch is still in flight.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
//   mem_req   : fetch request, held until mem_ack
//   mem_addr  : word address of the fetch
//   mem_ack   : memory returns data this cycle (single-cycle pulse is enough)
//   mem_rdata : fetched word, valid with mem_ack
//   mem_err   : bus error, qualified by mem_ack
interface instr_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      input  mem_err
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata,
      output mem_err
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the program counter, fetches one 32-bit word
// per request from instruction memory and presents it to controlpath.
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   pc_inc      : advance pc by 4 (only honoured while a valid word is shown)
//   pc_load     : redirect pc to pc_target
//   pc_target   : redirect address
//   mem         : instruction memory bus (master side)
//   instruction : registered instruction word
//   wait_instr  : no valid instruction is being presented
//   instr_segv  : sticky fetch fault (illegal address or bus error)
//   pc          : current program counter
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | one cycle after reset, decides fetch or fault for RESET_PC
// S_REQ   | fetch in flight, mem_req high, waiting for mem_ack
// S_VALID | instruction holds a valid word for pc
// S_FAULT | illegal address or bus error, left only by a legal pc_load
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] MEM_LIMIT = 32'h0000_FFFC
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pc_inc,
   input  logic               pc_load,
   input  logic [31:0]        pc_target,
   instr_fetch_if.master      mem,
   output logic [31:0]        instruction,
   output logic               wait_instr,
   output logic               instr_segv,
   output logic [31:0]        pc
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] inflight_q, inflight_nxt;
   logic        redirect_pending, redirect_pending_nxt;

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= MEM_LIMIT);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         pc_q             <= RESET_PC;
         instr_q          <= 32'h0;
         inflight_q       <= 32'h0;
         redirect_pending <= 1'b0;
      end else begin
         state            <= state_nxt;
         pc_q             <= pc_nxt;
         instr_q          <= instr_nxt;
         inflight_q       <= inflight_nxt;
         redirect_pending <= redirect_pending_nxt;
      end
   end

   always_comb begin
      state_nxt            = state;
      pc_nxt               = pc_q;
      instr_nxt            = instr_q;
      inflight_nxt         = inflight_q;
      redirect_pending_nxt = redirect_pending;

      unique case (state)
         S_IDLE: begin
            state_nxt = legal(pc_q) ? S_REQ : S_FAULT;
         end

         S_REQ: begin
            if (mem.mem_ack) begin
               redirect_pending_nxt = 1'b0;
               if (pc_load) begin
                  // redirect coinciding with ack: the returned word belongs to
                  // the old pc, so drop it and restart at the target
                  pc_nxt    = pc_target;
                  state_nxt = legal(pc_target) ? S_REQ : S_FAULT;
               end else if (redirect_pending) begin
                  // stale word for the pre-redirect address; refetch at pc
                  state_nxt = legal(pc_q) ? S_REQ : S_FAULT;
               end else if (mem.mem_err) begin
                  state_nxt = S_FAULT;
               end else begin
                  instr_nxt = mem.mem_rdata;
                  state_nxt = S_VALID;
               end
            end else if (pc_load) begin
               // keep the bus address stable until the in-flight ack; only the
               // first redirect captures it, later ones just move pc again
               pc_nxt               = pc_target;
               redirect_pending_nxt = 1'b1;
               if (!redirect_pending) begin
                  inflight_nxt = pc_q;
               end
            end
         end

         S_VALID: begin
            if (pc_load) begin
               pc_nxt    = pc_target;
               state_nxt = legal(pc_target) ? S_REQ : S_FAULT;
            end else if (pc_inc) begin
               pc_nxt    = pc_q + 32'd4;
               state_nxt = legal(pc_q + 32'd4) ? S_REQ : S_FAULT;
            end
         end

         S_FAULT: begin
            if (pc_load) begin
               pc_nxt = pc_target;
               if (legal(pc_target)) begin
                  state_nxt = S_REQ;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem.mem_req  = (state == S_REQ);
   assign mem.mem_addr = redirect_pending ? inflight_q : pc_q;
   assign wait_instr   = (state != S_VALID);
   assign instr_segv   = (state == S_FAULT);
   assign instruction  = instr_q;
   assign pc           = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] MEM_LIMIT = 32'h0000_FFFC;
   localparam int          N_VEC     = 24;
   localparam int          N_RAND    = 3000;

   logic        clk;
   logic        reset_n;
   logic        pc_inc;
   logic        pc_load;
   logic [31:0] pc_target;
   logic [31:0] instruction;
   logic        wait_instr;
   logic        instr_segv;
   logic [31:0] pc;

   instr_fetch_if bus ();

   instr_fetch #(
      .RESET_PC  (RESET_PC),
      .MEM_LIMIT (MEM_LIMIT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .mem         (bus.master),
      .instruction (instruction),
      .wait_instr  (wait_instr),
      .instr_segv  (instr_segv),
      .pc          (pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic inc, input logic load, input logic [31:0] tgt,
                        input logic ack, input logic err, input logic [31:0] rdata);
      pc_inc        = inc;
      pc_load       = load;
      pc_target     = tgt;
      bus.mem_ack   = ack;
      bus.mem_err   = err;
      bus.mem_rdata = rdata;
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_wait, input logic e_segv,
                             input logic [31:0] e_instr, input logic [31:0] e_pc);
      check({tag, " mem_req"},     {31'h0, bus.mem_req}, {31'h0, e_req});
      if (e_req) check({tag, " mem_addr"}, bus.mem_addr, e_addr);
      check({tag, " wait_instr"},  {31'h0, wait_instr},  {31'h0, e_wait});
      check({tag, " instr_segv"},  {31'h0, instr_segv},  {31'h0, e_segv});
      check({tag, " instruction"}, instruction, e_instr);
      check({tag, " pc"},          pc, e_pc);
   endtask

   // reset asserted for two edges, released just after a rising edge
   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, RESET_PC);
      reset_n = 1'b1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        inc;
      logic        load;
      logic [31:0] tgt;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_wait;
      logic        e_segv;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs [N_VEC];

   function automatic vec_t mk(logic inc, logic load, logic [31:0] tgt, logic ack, logic err,
                               logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                               logic e_wait, logic e_segv, logic [31:0] e_instr,
                               logic [31:0] e_pc);
      vec_t v;
      v.inc = inc; v.load = load; v.tgt = tgt; v.ack = ack; v.err = err; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_wait = e_wait; v.e_segv = e_segv;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   // ---------------- reference model ----------------
   // Tracks the fetch as "what is on the bus / what is presented / faulted"
   // flags rather than a state variable.
   logic        m_boot, m_fetching, m_have, m_fault, m_stale;
   logic [31:0] m_pc, m_instr, m_bus_addr;

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= MEM_LIMIT);
   endfunction

   task automatic m_reset();
      m_boot = 1'b1; m_fetching = 1'b0; m_have = 1'b0; m_fault = 1'b0; m_stale = 1'b0;
      m_pc = RESET_PC; m_instr = 32'h0; m_bus_addr = 32'h0;
   endtask

   task automatic m_begin_fetch(input logic [31:0] a);
      if (legal(a)) begin
         m_fetching = 1'b1;
         m_bus_addr = a;
      end else begin
         m_fault = 1'b1;
      end
   endtask

   task automatic m_step(input logic inc, input logic load, input logic [31:0] tgt,
                         input logic ack, input logic err, input logic [31:0] rdata);
      if (m_boot) begin
         m_boot = 1'b0;
         m_begin_fetch(m_pc);
      end else if (m_fetching) begin
         if (ack) begin
            m_fetching = 1'b0;
            if (load) begin
               m_pc    = tgt;
               m_stale = 1'b0;
               m_begin_fetch(m_pc);
            end else if (m_stale) begin
               m_stale = 1'b0;
               m_begin_fetch(m_pc);
            end else if (err) begin
               m_fault = 1'b1;
            end else begin
               m_instr = rdata;
               m_have  = 1'b1;
            end
         end else if (load) begin
            m_pc    = tgt;
            m_stale = 1'b1;
         end
      end else if (m_have) begin
         if (load) begin
            m_have = 1'b0;
            m_pc   = tgt;
            m_begin_fetch(m_pc);
         end else if (inc) begin
            m_have = 1'b0;
            m_pc   = m_pc + 32'd4;
            m_begin_fetch(m_pc);
         end
      end else if (m_fault) begin
         if (load) begin
            m_pc = tgt;
            if (legal(tgt)) begin
               m_fault = 1'b0;
               m_begin_fetch(m_pc);
            end
         end
      end
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      case ($urandom_range(0, 5))
         0: t = $urandom_range(0, 32'h3FFF) << 2;
         1: t = ($urandom_range(0, 32'h3FFF) << 2) | $urandom_range(1, 3);
         2: t = MEM_LIMIT;
         3: t = MEM_LIMIT + 32'd4;
         4: t = 32'hFFFF_FFFC;
         default: t = $urandom;
      endcase
      return t;
   endfunction

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      //              inc load tgt           ack err rdata          req addr          wait segv instr          pc
      vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h0,        1, 0, 32'h0,          32'h0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h0,        1, 0, 32'h0,          32'h0);
      vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h0,        1, 0, 32'h0,          32'h0);
      vecs[3]  = mk(0, 0, 32'h0,        1, 0, 32'h4000_0001,  0, 32'h0,        0, 0, 32'h4000_0001,  32'h0);
      vecs[4]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h4,        1, 0, 32'h4000_0001,  32'h4);
      vecs[5]  = mk(1, 0, 32'h0,        1, 0, 32'h11,         0, 32'h0,        0, 0, 32'h11,         32'h4);
      vecs[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h8,        1, 0, 32'h11,         32'h8);
      vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h8,        1, 0, 32'h11,         32'h8);
      vecs[8]  = mk(0, 1, 32'h100,      0, 0, 32'h0,          1, 32'h8,        1, 0, 32'h11,         32'h100);
      vecs[9]  = mk(0, 0, 32'h0,        1, 0, 32'hDEAD,       1, 32'h100,      1, 0, 32'h11,         32'h100);
      vecs[10] = mk(0, 0, 32'h0,        1, 0, 32'h0100_AAAA,  0, 32'h0,        0, 0, 32'h0100_AAAA,  32'h100);
      vecs[11] = mk(0, 1, 32'h102,      0, 0, 32'h0,          0, 32'h0,        1, 1, 32'h0100_AAAA,  32'h102);
      vecs[12] = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 1, 32'h0100_AAAA,  32'h102);
      vecs[13] = mk(0, 1, 32'h1_0000,   0, 0, 32'h0,          0, 32'h0,        1, 1, 32'h0100_AAAA,  32'h1_0000);
      vecs[14] = mk(0, 1, 32'h200,      0, 0, 32'h0,          1, 32'h200,      1, 0, 32'h0100_AAAA,  32'h200);
      vecs[15] = mk(0, 0, 32'h0,        1, 1, 32'h5555,       0, 32'h0,        1, 1, 32'h0100_AAAA,  32'h200);
      vecs[16] = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 1, 32'h0100_AAAA,  32'h200);
      vecs[17] = mk(0, 1, 32'hFFFC,     0, 0, 32'h0,          1, 32'hFFFC,     1, 0, 32'h0100_AAAA,  32'hFFFC);
      vecs[18] = mk(0, 0, 32'h0,        1, 0, 32'h77,         0, 32'h0,        0, 0, 32'h77,         32'hFFFC);
      vecs[19] = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 1, 32'h77,         32'h1_0000);
      vecs[20] = mk(0, 1, 32'h300,      0, 0, 32'h0,          1, 32'h300,      1, 0, 32'h77,         32'h300);
      vecs[21] = mk(0, 1, 32'h400,      1, 0, 32'h99,         1, 32'h400,      1, 0, 32'h77,         32'h400);
      vecs[22] = mk(0, 0, 32'h0,        1, 0, 32'h4444,       0, 32'h0,        0, 0, 32'h4444,       32'h400);
      vecs[23] = mk(0, 0, 32'h0,        1, 0, 32'h1234,       0, 32'h0,        0, 0, 32'h4444,       32'h400);

      do_reset();
      for (int i = 0; i < N_VEC; i++) begin
         drive(vecs[i].inc, vecs[i].load, vecs[i].tgt, vecs[i].ack, vecs[i].err, vecs[i].rdata);
         @(posedge clk);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_wait,
                    vecs[i].e_segv, vecs[i].e_instr, vecs[i].e_pc);
      end

      // reset while a fetch is in flight, ack arriving during reset
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_outs("mid pre", 1'b1, 32'h404, 1'b1, 1'b0, 32'h4444, 32'h404);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("mid async", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, RESET_PC);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hBAD0_BAD0);
      @(posedge clk);
      #1;
      check_outs("mid ack", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, RESET_PC);
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_outs("mid refetch", 1'b1, RESET_PC, 1'b1, 1'b0, 32'h0, RESET_PC);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600D);
      @(posedge clk);
      #1;
      check_outs("mid valid", 1'b0, 32'h0, 1'b0, 1'b0, 32'h600D, RESET_PC);

      // randomized run against the reference model
      do_reset();
      m_reset();
      begin
         int  lat;
         bit  counting;
         logic        r_inc, r_load, r_ack, r_err;
         logic [31:0] r_tgt, r_rdata;
         counting = 1'b0;
         lat      = 0;
         for (int c = 0; c < N_RAND; c++) begin
            r_inc   = ($urandom_range(0, 1) == 1);
            r_load  = !m_boot && ($urandom_range(0, 5) == 0);
            r_tgt   = rand_target();
            r_rdata = $urandom;
            r_err   = ($urandom_range(0, 9) == 0);
            r_ack   = 1'b0;
            if (bus.mem_req) begin
               if (!counting) begin
                  lat      = $urandom_range(0, 3);
                  counting = 1'b1;
               end
               if (lat == 0) begin
                  r_ack    = 1'b1;
                  counting = 1'b0;
               end else begin
                  lat--;
               end
            end else begin
               counting = 1'b0;
               r_ack    = ($urandom_range(0, 7) == 0);
            end
            drive(r_inc, r_load, r_tgt, r_ack, r_err, r_rdata);
            @(posedge clk);
            m_step(r_inc, r_load, r_tgt, r_ack, r_err, r_rdata);
            #1;
            check_outs($sformatf("rand%0d", c), m_fetching, m_bus_addr, !m_have, m_fault,
                       m_instr, m_pc);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
